// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and enums for simple_4bit_processor and its program loader
package proc_pkg;

  localparam int DEPTH = 32;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [7:0] NOP_WORD = 8'hC0;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    ADD  = 2'b01,
    SUB  = 2'b10,
    NOP  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    FILL,
    RECV,
    DONE,
    ERROR
  } load_state_e;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - valid/ready machine-code byte stream into the program loader
interface program_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/program_loader_checksum.sv
// rtl/program_loader_checksum.sv - mod-256 running sum of accepted bytes; only built with PROGRAM_LOADER_CHECKSUM_EN
`ifdef PROGRAM_LOADER_CHECKSUM_EN
module program_loader_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] total
);

  logic [7:0] acc_q, acc_d;

  // total includes the byte on the bus so the checksum verdict is known on its handshake
  always_comb begin
    total = acc_q + data;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = total;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`endif

// File: rtl/program_loader.sv
// rtl/program_loader.sv - NOP-fills instruction memory, loads a byte stream, then releases the CPU reset
// PROGRAM_LOADER_CHECKSUM_EN: final s_last byte is a checksum that must bring the byte sum to zero
module program_loader
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.slave   s,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   byte_count
);

  localparam int LAST_IDX = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_IDX[ADDR_W-1:0];
  localparam logic [ADDR_W:0] COUNT_MAX = DEPTH[ADDR_W:0];

  load_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic cpu_reset_q, cpu_reset_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic hs, at_end, prog_byte;

  assign hs     = s.s_valid && (state_q == RECV);
  assign at_end = (ptr_q == LAST_ADDR);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] sum_total;

  program_loader_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == FILL),
    .add   (hs),
    .data  (s.s_data),
    .total (sum_total)
  );

  assign prog_byte = hs && !s.s_last;
`else
  assign prog_byte = hs;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        ptr_d = ptr_q + 1'b1;
        if (at_end) state_d = RECV;
      end
      RECV: begin
        if (prog_byte) begin
          ptr_d = ptr_q + 1'b1;
          if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
        end
        // s_last takes priority so a checksum may land at the last address
        if (hs && s.s_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = (sum_total == 8'd0) ? DONE : ERROR;
`else
          state_d = DONE;
`endif
        end else if (hs && at_end) begin
          state_d = ERROR;
        end
      end
      default: begin
        if (start) begin
          state_d = FILL;
          ptr_d   = '0;
          count_d = '0;
        end
      end
    endcase
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      ptr_q       <= '0;
      count_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign s.s_ready  = (state_q == RECV);
  assign mem_we     = reset && ((state_q == FILL) || prog_byte);
  assign mem_addr   = ptr_q;
  assign mem_wdata  = (state_q == FILL) ? NOP_WORD : s.s_data;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader; honours PROGRAM_LOADER_CHECKSUM_EN
module tb_program_loader;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic cpu_reset, load_done, load_error;
  logic [ADDR_W:0] byte_count;

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s          (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every memory write must match the next expected one
  always @(negedge clk) begin : monitor
    logic [ADDR_W+7:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[ADDR_W+7:8]));
        check("write_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.s_last = 1'($urandom);
      bus.s_data = 8'($urandom);
    end
  endtask

  task automatic wait_fill();
    int n = 0;
    logic bad = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), NOP_WORD});
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("restart_byte_count", 32'(byte_count), 0);
        check("restart_done", 32'(load_done), 0);
        check("restart_error", 32'(load_error), 0);
      end
      if (cpu_reset !== 1'b1) bad = 1'b1;
    end while (bus.s_ready !== 1'b1 && n < 40);
    check("fill_cycles_to_ready", n, DEPTH + 1);
    check("fill_cpu_reset_held", 32'(bad), 0);
    check("fill_writes_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_error", 32'(load_error), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_fill();
  endtask

  task automatic restart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_fill();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, output logic acc);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.s_last  = l;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        acc = 1'b1;
        check("hs_cpu_reset", 32'(cpu_reset), 1);
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'($urandom);
    bus.s_data  = 8'($urandom);
  endtask

  // reference model: which bytes land where, and how the load ends
  task automatic run_program(input bit has_last, input int gap, input bit rnd);
    int n_acc = 0;
    int p = 0;
    bit done = 0, err = 0;
    logic [7:0] sum = 8'd0;
    logic acc;
    int n = prog.size();
    for (int i = 0; i < n; i++) begin
      if (done || err) break;
      n_acc++;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum = sum + prog[i];
      if (has_last && i == n - 1) begin
        if (sum == 8'd0) done = 1; else err = 1;
      end else begin
        exp_q.push_back({ADDR_W'(p), prog[i]});
        p++;
        if (p == DEPTH) err = 1;
      end
`else
      exp_q.push_back({ADDR_W'(p), prog[i]});
      p++;
      if (has_last && i == n - 1) done = 1;
      else if (p == DEPTH) err = 1;
`endif
    end
    for (int i = 0; i < n; i++) begin
      send_byte(prog[i], has_last && (i == n - 1), acc);
      if (i < n_acc) begin
        check("byte_accepted", 32'(acc), 1);
      end else begin
        check("byte_refused", 32'(acc), 0);
        break;
      end
      if (i < n_acc - 1) idle(rnd ? int'($urandom_range(0, gap)) : gap);
    end
    @(negedge clk);
    check("end_load_done", 32'(load_done), 32'(done));
    check("end_load_error", 32'(load_error), 32'(err));
    check("end_cpu_reset", 32'(cpu_reset), 32'(!done));
    check("end_byte_count", 32'(byte_count), p);
    check("end_s_ready", 32'(bus.s_ready), 0);
    check("end_writes_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [7:0] sum;
    bit has_last;
    int k;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    do_reset();

    for (int g = 0; g <= 3; g += 3) begin
      prog = '{8'h05, 8'h13, 8'h61, 8'hB9};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      prog.push_back(8'hCE);
`endif
      run_program(1'b1, g, 1'b0);
      restart();
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    prog = '{8'h05, 8'h13, 8'h61, 8'hB9, 8'hCF};
    run_program(1'b1, 0, 1'b0);
    restart();
`endif

    prog.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog.push_back(8'($urandom));
    run_program(1'b0, 2, 1'b1);
    restart();

    for (int i = 0; i < 2; i++) begin
      prog[i] = 8'($urandom);
      exp_q.push_back({ADDR_W'(i), prog[i]});
      send_byte(prog[i], 1'b0, acc);
      check("midload_accepted", 32'(acc), 1);
    end
    do_reset();

    for (int it = 0; it < 12; it++) begin
      prog.delete();
      has_last = ($urandom_range(0, 3) != 0);
      if (has_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        k = $urandom_range(0, DEPTH - 1);
        sum = 8'd0;
        for (int i = 0; i < k; i++) begin
          prog.push_back(8'($urandom));
          sum = sum + prog[i];
        end
        sum = 8'd0 - sum;
        if ($urandom_range(0, 1) == 1) sum = sum + 8'($urandom_range(1, 255));
        prog.push_back(sum);
`else
        k = $urandom_range(1, DEPTH);
        for (int i = 0; i < k; i++) prog.push_back(8'($urandom));
`endif
      end else begin
        for (int i = 0; i < DEPTH + 1; i++) prog.push_back(8'($urandom));
      end
      run_program(has_last, 3, 1'b1);
      restart();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
